// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared types and constants for the DLX memory stage
package dlx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO               = 5'd0;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter for an outstanding data access
// Fires in the last allowed wait cycle so the stall drops on the same edge the access is abandoned.
module mem_wait_timer
  import dlx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (active && !ack) begin
      count_d = count_q + CW'(1);
    end
  end

  assign expired = active & ~ack & (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - DLX memory-access stage: req/ack data port, stall, WB register, MEM->EX forwarding
// Access timeout with error retire is compiled in only when DLX_MEM_TIMEOUT_EN is defined.
module mem_stage
  import dlx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_out_MEM,
  input  logic        d_write_enable_MEM,
  input  logic        d_load_enable_MEM,
  input  logic [4:0]  Rd_MEM,
  input  logic [4:0]  Rs2_MEM,
  input  logic [31:0] S2_MEM,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_we,
  output logic        d_req,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        stall_MEM,
  output logic [31:0] ALU_out_MEM_backward,
  output logic [4:0]  Rd_MEM_backward,
  output logic [31:0] data_WB,
  output logic [4:0]  Rd_WB,
  output logic        mem_err_WB
);

  mem_state_t  state_q, state_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [31:0] data_wb_q, data_wb_d;
  logic        mem_err_q, mem_err_d;
  logic        mem_op, in_idle, in_wait, done, timeout;

  assign mem_op  = d_load_enable_MEM | d_write_enable_MEM;
  assign in_idle = (state_q == IDLE);
  assign in_wait = (state_q == WAIT);

  // Gating with reset lets the request drop the instant reset rises, even mid-access.
  assign d_req     = ~reset & ((in_idle & mem_op) | in_wait);
  assign done      = d_req & d_ack;
  assign stall_MEM = d_req & ~d_ack & ~timeout;

`ifdef DLX_MEM_TIMEOUT_EN
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (in_idle & mem_op & ~d_ack),
    .active (in_wait),
    .ack    (d_ack),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  assign d_addr  = ALU_out_MEM;
  assign d_we    = d_write_enable_MEM;
  assign d_wdata = ((Rs2_MEM != REG_ZERO) && (Rs2_MEM == rd_wb_q)) ? data_wb_q : S2_MEM;

  assign ALU_out_MEM_backward = ALU_out_MEM;
  assign Rd_MEM_backward      = mem_op ? REG_ZERO : Rd_MEM;

  always_comb begin
    state_d   = state_q;
    rd_wb_d   = REG_ZERO;
    data_wb_d = data_wb_q;
    mem_err_d = timeout;

    case (state_q)
      IDLE:    if (mem_op && !d_ack) state_d = WAIT;
      WAIT:    if (d_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A store retires as a bubble; stalled and timed-out cycles also retire bubbles.
    if (done) begin
      if (!d_write_enable_MEM) begin
        rd_wb_d   = Rd_MEM;
        data_wb_d = d_rdata;
      end
    end else if (!mem_op) begin
      rd_wb_d   = Rd_MEM;
      data_wb_d = ALU_out_MEM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_wb_q   <= REG_ZERO;
      data_wb_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_wb_q   <= rd_wb_d;
      data_wb_q <= data_wb_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign Rd_WB      = rd_wb_q;
  assign data_WB    = data_wb_q;
  assign mem_err_WB = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_out_MEM;
  logic        d_write_enable_MEM;
  logic        d_load_enable_MEM;
  logic [4:0]  Rd_MEM;
  logic [4:0]  Rs2_MEM;
  logic [31:0] S2_MEM;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_req;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        stall_MEM;
  logic [31:0] ALU_out_MEM_backward;
  logic [4:0]  Rd_MEM_backward;
  logic [31:0] data_WB;
  logic [4:0]  Rd_WB;
  logic        mem_err_WB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ALU_out_MEM         (ALU_out_MEM),
    .d_write_enable_MEM  (d_write_enable_MEM),
    .d_load_enable_MEM   (d_load_enable_MEM),
    .Rd_MEM              (Rd_MEM),
    .Rs2_MEM             (Rs2_MEM),
    .S2_MEM              (S2_MEM),
    .d_addr              (d_addr),
    .d_wdata             (d_wdata),
    .d_we                (d_we),
    .d_req               (d_req),
    .d_ack               (d_ack),
    .d_rdata             (d_rdata),
    .stall_MEM           (stall_MEM),
    .ALU_out_MEM_backward(ALU_out_MEM_backward),
    .Rd_MEM_backward     (Rd_MEM_backward),
    .data_WB             (data_WB),
    .Rd_WB               (Rd_WB),
    .mem_err_WB          (mem_err_WB)
  );

  task automatic idle_inputs();
    ALU_out_MEM        = 32'h0;
    d_write_enable_MEM = 1'b0;
    d_load_enable_MEM  = 1'b0;
    Rd_MEM             = 5'd0;
    Rs2_MEM            = 5'd0;
    S2_MEM             = 32'h0;
    d_ack              = 1'b0;
    d_rdata            = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    vectors++; if (Rd_WB !== 5'd0) begin miscompares++; $display("FAIL reset_rd_wb: got %0d expected 0", Rd_WB); end
    vectors++; if (data_WB !== 32'h0) begin miscompares++; $display("FAIL reset_data_wb: got %h expected 0", data_WB); end
    vectors++; if (mem_err_WB !== 1'b0) begin miscompares++; $display("FAIL reset_mem_err: got %b expected 0", mem_err_WB); end
    vectors++; if (d_req !== 1'b0 || stall_MEM !== 1'b0) begin miscompares++; $display("FAIL reset_req_stall: got req=%b stall=%b expected 0/0", d_req, stall_MEM); end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_alu();
    ALU_out_MEM = 32'h1234;
    Rd_MEM      = 5'd5;
    @(negedge clk);
    vectors++; if (stall_MEM !== 1'b0 || d_req !== 1'b0) begin miscompares++; $display("FAIL alu_no_stall: got stall=%b req=%b expected 0/0", stall_MEM, d_req); end
    vectors++; if (Rd_MEM_backward !== 5'd5) begin miscompares++; $display("FAIL alu_fwd_tag: got %0d expected 5", Rd_MEM_backward); end
    vectors++; if (ALU_out_MEM_backward !== 32'h1234) begin miscompares++; $display("FAIL alu_fwd_val: got %h expected 00001234", ALU_out_MEM_backward); end
    step();
    vectors++; if (Rd_WB !== 5'd5 || data_WB !== 32'h1234) begin miscompares++; $display("FAIL alu_wb: got rd=%0d data=%h expected 5/00001234", Rd_WB, data_WB); end
    idle_inputs();
  endtask

  task automatic test_load_wait();
    int stall_cnt;
    stall_cnt = 0;
    ALU_out_MEM       = 32'h40;
    d_load_enable_MEM = 1'b1;
    Rd_MEM            = 5'd7;
    for (int i = 0; i < 4; i++) begin
      d_ack   = (i == 3);
      d_rdata = (i == 3) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      if (stall_MEM === 1'b1) stall_cnt++;
      if (i == 0) begin
        vectors++; if (d_req !== 1'b1 || d_we !== 1'b0 || d_addr !== 32'h40) begin miscompares++; $display("FAIL load_req: got req=%b we=%b addr=%h expected 1/0/00000040", d_req, d_we, d_addr); end
        vectors++; if (Rd_MEM_backward !== 5'd0) begin miscompares++; $display("FAIL load_no_fwd: got %0d expected 0", Rd_MEM_backward); end
      end
      step();
      if (i < 3) begin
        vectors++; if (Rd_WB !== 5'd0) begin miscompares++; $display("FAIL load_bubble_%0d: got %0d expected 0", i, Rd_WB); end
      end
    end
    vectors++; if (stall_cnt != 3) begin miscompares++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_cnt); end
    vectors++; if (Rd_WB !== 5'd7 || data_WB !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_wb: got rd=%0d data=%h expected 7/deadbeef", Rd_WB, data_WB); end
    idle_inputs();
    @(negedge clk);
    vectors++; if (d_req !== 1'b0) begin miscompares++; $display("FAIL load_back_idle: got req=%b expected 0", d_req); end
    step();
  endtask

  task automatic test_store_fwd();
    ALU_out_MEM = 32'hAA;
    Rd_MEM      = 5'd3;
    step();
    idle_inputs();
    d_write_enable_MEM = 1'b1;
    Rs2_MEM            = 5'd3;
    S2_MEM             = 32'h55;
    ALU_out_MEM        = 32'h80;
    d_ack              = 1'b1;
    @(negedge clk);
    vectors++; if (d_wdata !== 32'hAA) begin miscompares++; $display("FAIL store_fwd_wb: got %h expected 000000aa", d_wdata); end
    vectors++; if (d_we !== 1'b1 || d_addr !== 32'h80 || stall_MEM !== 1'b0) begin miscompares++; $display("FAIL store_req: got we=%b addr=%h stall=%b expected 1/00000080/0", d_we, d_addr, stall_MEM); end
    step();
    vectors++; if (Rd_WB !== 5'd0) begin miscompares++; $display("FAIL store_wb_bubble: got %0d expected 0", Rd_WB); end
    idle_inputs();
    ALU_out_MEM = 32'hBB;
    Rd_MEM      = 5'd4;
    step();
    idle_inputs();
    d_write_enable_MEM = 1'b1;
    Rs2_MEM            = 5'd3;
    S2_MEM             = 32'h55;
    d_ack              = 1'b1;
    @(negedge clk);
    vectors++; if (d_wdata !== 32'h55) begin miscompares++; $display("FAIL store_no_fwd: got %h expected 00000055", d_wdata); end
    step();
    Rs2_MEM = 5'd0;
    S2_MEM  = 32'h66;
    @(negedge clk);
    vectors++; if (d_wdata !== 32'h66) begin miscompares++; $display("FAIL store_r0_no_fwd: got %h expected 00000066", d_wdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_both_enables();
    d_write_enable_MEM = 1'b1;
    d_load_enable_MEM  = 1'b1;
    Rd_MEM             = 5'd9;
    ALU_out_MEM        = 32'h200;
    @(negedge clk);
    vectors++; if (d_we !== 1'b1 || stall_MEM !== 1'b1) begin miscompares++; $display("FAIL both_we_stall: got we=%b stall=%b expected 1/1", d_we, stall_MEM); end
    step();
    d_ack   = 1'b1;
    d_rdata = 32'h1111;
    @(negedge clk);
    vectors++; if (stall_MEM !== 1'b0) begin miscompares++; $display("FAIL both_ack_stall: got %b expected 0", stall_MEM); end
    step();
    vectors++; if (Rd_WB !== 5'd0) begin miscompares++; $display("FAIL both_wb: got %0d expected 0", Rd_WB); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    d_load_enable_MEM = 1'b1;
    Rd_MEM            = 5'd10;
    ALU_out_MEM       = 32'h100;
    d_ack             = 1'b1;
    d_rdata           = 32'h11;
    @(negedge clk);
    vectors++; if (stall_MEM !== 1'b0 || d_req !== 1'b1) begin miscompares++; $display("FAIL b2b_zero_wait: got stall=%b req=%b expected 0/1", stall_MEM, d_req); end
    step();
    vectors++; if (Rd_WB !== 5'd10 || data_WB !== 32'h11) begin miscompares++; $display("FAIL b2b_first_wb: got rd=%0d data=%h expected 10/00000011", Rd_WB, data_WB); end
    Rd_MEM      = 5'd11;
    ALU_out_MEM = 32'h104;
    d_ack       = 1'b0;
    @(negedge clk);
    vectors++; if (d_req !== 1'b1 || d_addr !== 32'h104 || stall_MEM !== 1'b1) begin miscompares++; $display("FAIL b2b_second_req: got req=%b addr=%h stall=%b expected 1/00000104/1", d_req, d_addr, stall_MEM); end
    step();
    d_ack   = 1'b1;
    d_rdata = 32'h22;
    step();
    vectors++; if (Rd_WB !== 5'd11 || data_WB !== 32'h22) begin miscompares++; $display("FAIL b2b_second_wb: got rd=%0d data=%h expected 11/00000022", Rd_WB, data_WB); end
    idle_inputs();
    ALU_out_MEM = 32'h33;
    Rd_MEM      = 5'd12;
    d_ack       = 1'b1;
    d_rdata     = 32'h99;
    @(negedge clk);
    vectors++; if (d_req !== 1'b0 || stall_MEM !== 1'b0) begin miscompares++; $display("FAIL stray_ack_req: got req=%b stall=%b expected 0/0", d_req, stall_MEM); end
    step();
    vectors++; if (Rd_WB !== 5'd12 || data_WB !== 32'h33) begin miscompares++; $display("FAIL stray_ack_wb: got rd=%0d data=%h expected 12/00000033", Rd_WB, data_WB); end
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    ALU_out_MEM = 32'h5;
    Rd_MEM      = 5'd5;
    step();
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (Rd_WB !== 5'd0 || data_WB !== 32'h0) begin miscompares++; $display("FAIL async_reset_wb: got rd=%0d data=%h expected 0/0", Rd_WB, data_WB); end
    step();
    reset = 1'b0;
    idle_inputs();
    d_load_enable_MEM = 1'b1;
    Rd_MEM            = 5'd13;
    ALU_out_MEM       = 32'h300;
    step();
    vectors++; if (stall_MEM !== 1'b1) begin miscompares++; $display("FAIL rst_wait_entry: got stall=%b expected 1", stall_MEM); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (d_req !== 1'b0 || stall_MEM !== 1'b0 || Rd_WB !== 5'd0) begin miscompares++; $display("FAIL rst_in_wait: got req=%b stall=%b rd=%0d expected 0/0/0", d_req, stall_MEM, Rd_WB); end
    step();
    reset = 1'b0;
    idle_inputs();
    ALU_out_MEM = 32'h77;
    Rd_MEM      = 5'd14;
    d_ack       = 1'b1;
    d_rdata     = 32'hBAD;
    @(negedge clk);
    vectors++; if (d_req !== 1'b0) begin miscompares++; $display("FAIL stale_ack_req: got %b expected 0", d_req); end
    step();
    vectors++; if (Rd_WB !== 5'd14 || data_WB !== 32'h77) begin miscompares++; $display("FAIL stale_ack_wb: got rd=%0d data=%h expected 14/00000077", Rd_WB, data_WB); end
    idle_inputs();
  endtask

`ifdef DLX_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int stall_cnt;
    int req_cnt;
    int err_early;
    stall_cnt = 0;
    req_cnt   = 0;
    err_early = 0;
    d_load_enable_MEM = 1'b1;
    Rd_MEM            = 5'd15;
    ALU_out_MEM       = 32'h400;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall_MEM === 1'b1) stall_cnt++;
      if (d_req === 1'b1) req_cnt++;
      step();
      if (i < 4 && mem_err_WB !== 1'b0) err_early++;
    end
    vectors++; if (stall_cnt != 4 || req_cnt != 5) begin miscompares++; $display("FAIL timeout_cycles: got stall=%0d req=%0d expected 4/5", stall_cnt, req_cnt); end
    vectors++; if (err_early != 0) begin miscompares++; $display("FAIL timeout_early_err: got %0d expected 0", err_early); end
    vectors++; if (mem_err_WB !== 1'b1 || Rd_WB !== 5'd0) begin miscompares++; $display("FAIL timeout_err: got err=%b rd=%0d expected 1/0", mem_err_WB, Rd_WB); end
    idle_inputs();
    @(negedge clk);
    vectors++; if (d_req !== 1'b0) begin miscompares++; $display("FAIL timeout_req_drop: got %b expected 0", d_req); end
    step();
    vectors++; if (mem_err_WB !== 1'b0) begin miscompares++; $display("FAIL timeout_err_pulse: got %b expected 0", mem_err_WB); end
    d_load_enable_MEM = 1'b1;
    Rd_MEM            = 5'd16;
    ALU_out_MEM       = 32'h404;
    for (int i = 0; i < 5; i++) begin
      d_ack   = (i == 4);
      d_rdata = 32'hCAFE0000;
      @(negedge clk);
      step();
    end
    vectors++; if (mem_err_WB !== 1'b0 || Rd_WB !== 5'd16 || data_WB !== 32'hCAFE0000) begin miscompares++; $display("FAIL timeout_ack_priority: got err=%b rd=%0d data=%h expected 0/16/cafe0000", mem_err_WB, Rd_WB, data_WB); end
    idle_inputs();
  endtask
`else
  task automatic test_no_timeout();
    int req_drop;
    int err_seen;
    req_drop = 0;
    err_seen = 0;
    d_load_enable_MEM = 1'b1;
    Rd_MEM            = 5'd17;
    ALU_out_MEM       = 32'h500;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_req !== 1'b1 || stall_MEM !== 1'b1) req_drop++;
      step();
      if (mem_err_WB !== 1'b0) err_seen++;
    end
    vectors++; if (req_drop != 0) begin miscompares++; $display("FAIL long_wait_req: got %0d dropped cycles expected 0", req_drop); end
    vectors++; if (err_seen != 0) begin miscompares++; $display("FAIL long_wait_err: got %0d error cycles expected 0", err_seen); end
    d_ack   = 1'b1;
    d_rdata = 32'h1717;
    step();
    vectors++; if (Rd_WB !== 5'd17 || data_WB !== 32'h1717) begin miscompares++; $display("FAIL long_wait_wb: got rd=%0d data=%h expected 17/00001717", Rd_WB, data_WB); end
    idle_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_fwd();
    test_both_enables();
    test_back_to_back();
    test_reset_in_wait();
`ifdef DLX_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage. Takes the registered ALU result, load/store enables, destination and store-source register indices, and performs the data-memory access over a req/ack handshake. Stalls the upstream pipeline while an access is outstanding. Registers the result into the write-back stage and supplies the MEM→EX forwarding pair.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: wait-cycle limit for an outstanding access; used only with `DLX_MEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ALU_out_MEM` in 32: address for loads/stores; result for ALU instructions.
- `d_write_enable_MEM` in 1: instruction is a store.
- `d_load_enable_MEM` in 1: instruction is a load.
- `Rd_MEM` in 5: destination register; 0 means no write-back.
- `Rs2_MEM` in 5: store-data source register index.
- `S2_MEM` in 32: register-file read of `Rs2_MEM`.
- `d_addr` out 32: data-memory address.
- `d_wdata` out 32: store data.
- `d_we` out 1: 1 = write, 0 = read.
- `d_req` out 1: access request.
- `d_ack` in 1: memory completes the access on this edge.
- `d_rdata` in 32: load data, valid when `d_ack`=1.
- `stall_MEM` out 1: upstream stages hold while high.
- `ALU_out_MEM_backward` out 32: forwarding value to EX.
- `Rd_MEM_backward` out 5: forwarding tag to EX; 0 = none.
- `data_WB` out 32: value to write back.
- `Rd_WB` out 5: write-back destination; 0 = none.
- `mem_err_WB` out 1: access aborted by timeout. Tied 0 without the macro.

## Operation
- FSM states:
  - `IDLE`: no access outstanding.
  - `WAIT`: request issued, ack not yet seen.
- Memory-op detection: `mem_op = d_load_enable_MEM | d_write_enable_MEM`. If both enables are high, the store wins and the load is ignored.
- Request: `d_req = (IDLE & mem_op) | WAIT`.
  - `d_we` = store.
  - `d_addr` = `ALU_out_MEM`.
  - Both are stable while `d_req` is high, because the upstream stage is stalled.
- Store data forwarding from WB: if `Rs2_MEM != 0` and `Rs2_MEM == Rd_WB`, then `d_wdata = data_WB`; otherwise `d_wdata = S2_MEM`.
- Stall: `stall_MEM = d_req & ~d_ack`.
- Transitions:
  - `IDLE` → `WAIT` when `mem_op` & ~`d_ack`.
  - `WAIT` → `IDLE` on `d_ack`.
  - `d_ack` while `d_req`=0 is ignored.
- Write-back register, updated every edge:
  - Access completing (`d_req & d_ack`):
    - load: `Rd_WB ← Rd_MEM`, `data_WB ← d_rdata`;
    - store: `Rd_WB ← 0`.
  - Non-memory instruction: `Rd_WB ← Rd_MEM`, `data_WB ← ALU_out_MEM`.
  - Stalled cycle: bubble, `Rd_WB ← 0`; `data_WB` is don't-care.
- Forwarding:
  - `ALU_out_MEM_backward = ALU_out_MEM`.
  - `Rd_MEM_backward = Rd_MEM`, except 0 for a load or store. Load results are not forwarded from MEM; load-use is resolved by the stall.

## Timing
- Reset values:
  - state `IDLE`;
  - `Rd_WB`=0, `data_WB`=0, `mem_err_WB`=0;
  - `d_req`=0 immediately on assertion, even mid-access.
  - The stale `d_ack` for an aborted access is ignored once `IDLE`.
- ALU instruction: 1-cycle latency MEM → WB, no stall.
- Zero-wait access (`d_ack` in the request cycle): no stall, 1-cycle latency.
- N wait cycles: `stall_MEM` high for N cycles; the result reaches WB on the edge after `d_ack`.
- Back-to-back memory ops: a new request is issued in the cycle after completion, never in the same cycle.

## Configuration
- `DLX_MEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to `WAIT` and increments each `WAIT` cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`: drop `d_req`, return to `IDLE`, release the stall.
  - Retire a bubble with `mem_err_WB`=1 for exactly one cycle.
  - A `d_ack` arriving in the timeout cycle takes priority; no error is raised.
- Undefined: no counter; `WAIT` lasts indefinitely; `mem_err_WB` is constant 0.

## Structure
- Shared package `dlx_pkg`:
  - state enum `mem_state_t {IDLE, WAIT}`;
  - `REG_ZERO` = 5'd0;
  - default `TIMEOUT_CYCLES`.
- One natural sub-module, `mem_wait_timer`: the timeout counter, instantiated only under the macro.
- Everything else stays flat.

## Test plan
- ALU instruction, `ALU_out_MEM`=0x1234, `Rd_MEM`=5 → next edge `Rd_WB`=5, `data_WB`=0x1234, `stall_MEM` never high.
- Load from 0x40, `Rd_MEM`=7, `d_ack` after 3 cycles with `d_rdata`=0xDEADBEEF → `stall_MEM` high for 3 cycles; bubbles (`Rd_WB`=0) during the stall; then `Rd_WB`=7, `data_WB`=0xDEADBEEF.
- Store with `Rs2_MEM`=3 while `Rd_WB`=3, `data_WB`=0xAA → `d_wdata`=0xAA, `d_we`=1; with `Rd_WB`=4 → `d_wdata`=`S2_MEM`.
- Both enables high → `d_we`=1; after ack, `Rd_WB`=0.
- `reset` asserted in `WAIT` → `d_req`, `stall_MEM`, `Rd_WB` go to 0 asynchronously; the following `d_ack` is ignored.
- With `DLX_MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack → `d_req` drops after 4 wait cycles; `mem_err_WB` pulses for 1 cycle; `Rd_WB`=0.
